// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and constants for the UART frame scheduler.
// Contents: FSM state enum, default frame header, payload/frame sizing and
// the byte-select helper used by the scheduler's byte mux.
// Macro UART_FRAME_CHECKSUM_EN: frames carry a 9th XOR checksum byte.
package uart_frame_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] HDR_DEFAULT   = 16'h55AA;
  localparam int unsigned PAYLOAD_BYTES = 6;
  localparam int unsigned PAYLOAD_W     = 48;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 9;

  function automatic logic [7:0] payload_xor(input logic [PAYLOAD_W-1:0] p);
    logic [7:0] x;
    x = '0;
    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
      x = x ^ p[8*i +: 8];
    end
    return x;
  endfunction
`else
  localparam int unsigned FRAME_BYTES = 8;
`endif

  // Byte idx of a frame: header high, header low, payload MSB first, checksum.
  function automatic logic [7:0] frame_byte(input logic [3:0]           idx,
                                            input logic [15:0]          hdr,
                                            input logic [PAYLOAD_W-1:0] p,
                                            input logic [7:0]           chk);
    logic [7:0] b;
    case (idx)
      4'd0:    b = hdr[15:8];
      4'd1:    b = hdr[7:0];
      4'd2:    b = p[47:40];
      4'd3:    b = p[39:32];
      4'd4:    b = p[31:24];
      4'd5:    b = p[23:16];
      4'd6:    b = p[15:8];
      4'd7:    b = p[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports: req (request vector), pointer (highest-priority index),
//        grant (one-hot), winner (grant index), any_req (some request set).
// pointer is expected to be below NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         winner,
  output logic               any_req
);

  logic found;

  // Distance-ordered search: for each distance k above the pointer (with
  // wrap) test every requester, so all bit selects stay constant.
  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            (((i + NUM_REQ - 32'(pointer)) % NUM_REQ) == k)) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          winner   = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: shares one byte-level UART transmitter between
// NUM_REQ producers. Round-robin grant, 48-bit payload latch, frames of
// HEADER (high byte first) + 6 payload bytes MSB first, then GAP_CYCLES idle.
// Ports: clock, reset_n (sync, active-low); req_valid/req_data/req_ready
//        requester side (payload i = req_data[48*i+47:48*i]); byte_data/
//        byte_valid/byte_ready serializer side; busy, grant_id, frame_done.
// Macro UART_FRAME_CHECKSUM_EN: appends XOR of the payload bytes as byte 9.
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter logic [15:0] HEADER     = HDR_DEFAULT,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*48-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic                   frame_done
);

  localparam logic [15:0] GAP_LOAD  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_BYTES - 1);
  localparam logic [2:0]  LAST_REQ  = 3'(NUM_REQ - 1);

  state_t               state;
  logic [2:0]           rr_ptr;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [2:0]           arb_winner;
  logic                 arb_any;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [3:0]           byte_idx;
  logic [15:0]          gap_cnt;
  logic [7:0]           chk_q;
  logic                 accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .pointer (rr_ptr),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  // Gated by reset_n so nothing is accepted on a reset edge.
  assign req_ready = (state == IDLE && reset_n) ? arb_grant : '0;
  assign accept    = byte_valid && byte_ready;

  always_comb begin
    sel_payload = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_payload = req_data[48*i +: 48];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      payload_q  <= '0;
      chk_q      <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (arb_any) begin
            payload_q  <= sel_payload;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q      <= payload_xor(sel_payload);
`endif
            grant_id   <= arb_winner;
            rr_ptr     <= (arb_winner == LAST_REQ) ? 3'd0 : arb_winner + 3'd1;
            byte_idx   <= '0;
            byte_data  <= HEADER[15:8];
            byte_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            if (byte_idx == LAST_IDX) begin
              byte_valid <= 1'b0;
              frame_done <= 1'b1;
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                gap_cnt <= GAP_LOAD;
                state   <= GAP;
              end
            end else begin
              byte_idx  <= byte_idx + 4'd1;
              byte_data <= frame_byte(byte_idx + 4'd1, HEADER, payload_q, chk_q);
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb_uart_frame_scheduler: randomized bench with a frame-level reference model.
// Two instances: dut0 (2 requesters, 16 gap cycles), dut1 (3 requesters, no gap).
// Phases: directed single frame, held round-robin, 1-0-0 backpressure,
// reset after the 3rd byte, then random requests and random byte_ready.
// Build with UART_FRAME_CHECKSUM_EN to expect 9-byte frames.
module tb_uart_frame_scheduler;

  localparam int NR0 = 2;
  localparam int G0  = 16;
  localparam int NR1 = 3;
  localparam int G1  = 0;
  localparam int NCYC = 3000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0][2:0]   rv;
  logic [1:0][143:0] rd;
  logic [1:0]        br;

  logic [1:0] rq0;
  logic [2:0] rq1;
  logic [7:0] bd0, bd1;
  logic       bv0, bv1, bz0, bz1, fd0, fd1;
  logic [2:0] gi0, gi1;

  uart_frame_scheduler #(.NUM_REQ(NR0), .HEADER(16'h55AA), .GAP_CYCLES(G0)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[0][1:0]), .req_data(rd[0][95:0]),
    .req_ready(rq0), .byte_data(bd0), .byte_valid(bv0), .byte_ready(br[0]),
    .busy(bz0), .grant_id(gi0), .frame_done(fd0)
  );

  uart_frame_scheduler #(.NUM_REQ(NR1), .HEADER(16'h55AA), .GAP_CYCLES(G1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(rv[1]), .req_data(rd[1]),
    .req_ready(rq1), .byte_data(bd1), .byte_valid(bv1), .byte_ready(br[1]),
    .busy(bz1), .grant_id(gi1), .frame_done(fd1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mode  = 0;
  bit rst_prev = 1'b1;
  bit did_rst  = 1'b0;

  // Reference model state, per instance.
  int         ptr_m     [2];
  int         free_at   [2];
  bit         in_frame  [2];
  int         grant_cyc [2];
  int         done_at   [2];
  logic [2:0] gid_m     [2];
  logic [7:0] frm       [2][9];
  int         pos       [2];
  int         flen      [2];
  logic [2:0] last_rq   [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int nr_of(input int d);
    return (d == 0) ? NR0 : NR1;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  task automatic model_reset(input int d);
    ptr_m[d]    = 0;
    in_frame[d] = 1'b0;
    free_at[d]  = cyc + 1;
    done_at[d]  = -1;
    gid_m[d]    = '0;
    pos[d]      = 0;
  endtask

  task automatic step(input int d);
    logic [2:0]  rq;
    logic [7:0]  bd;
    logic        bv, bz, fd;
    logic [2:0]  gi;
    logic [47:0] p;
    logic [7:0]  x;
    bit          idle, any;
    int          w, i, nr;
    string       pre;
    nr  = nr_of(d);
    pre = $sformatf("d%0d_", d);
    if (d == 0) begin
      rq = {1'b0, rq0}; bd = bd0; bv = bv0; bz = bz0; fd = fd0; gi = gi0;
    end else begin
      rq = rq1; bd = bd1; bv = bv1; bz = bz1; fd = fd1; gi = gi1;
    end
    last_rq[d] = rq;

    if (rst_prev) begin
      check_eq({pre, "rst_byte_valid"}, 64'(bv), 64'd0);
      check_eq({pre, "rst_busy"},       64'(bz), 64'd0);
      check_eq({pre, "rst_frame_done"}, 64'(fd), 64'd0);
      check_eq({pre, "rst_grant_id"},   64'(gi), 64'd0);
      check_eq({pre, "rst_byte_data"},  64'(bd), 64'd0);
    end

    if (!reset_n) begin
      check_eq({pre, "req_ready_in_reset"}, 64'(rq), 64'd0);
      model_reset(d);
      return;
    end

    idle = !in_frame[d] && (cyc >= free_at[d]);
    check_eq({pre, "busy"},       64'(bz), 64'(!idle));
    check_eq({pre, "frame_done"}, 64'(fd), 64'(cyc == done_at[d]));
    check_eq({pre, "grant_id"},   64'(gi), 64'(gid_m[d]));
    check_eq({pre, "byte_valid"}, 64'(bv), 64'(in_frame[d] && cyc > grant_cyc[d]));

    if (bv && in_frame[d] && cyc > grant_cyc[d]) begin
      check_eq($sformatf("%sbyte%0d", pre, pos[d]), 64'(bd), 64'(frm[d][pos[d]]));
      if (br[d]) begin
        pos[d]++;
        if (pos[d] == flen[d]) begin
          in_frame[d] = 1'b0;
          done_at[d]  = cyc + 1;
          free_at[d]  = cyc + 1 + gap_of(d);
        end
      end
    end

    if (idle) begin
      any = 1'b0;
      w   = 0;
      for (int k = 0; k < nr; k++) begin
        i = (ptr_m[d] + k) % nr;
        if (!any && rv[d][i]) begin
          any = 1'b1;
          w   = i;
        end
      end
      check_eq({pre, "req_ready"}, 64'(rq), any ? 64'(1 << w) : 64'd0);
      if (any) begin
        p = rd[d][48*w +: 48];
        frm[d][0] = 8'h55;
        frm[d][1] = 8'hAA;
        x = '0;
        for (int b = 0; b < 6; b++) begin
          frm[d][2+b] = p[47-8*b -: 8];
          x = x ^ p[47-8*b -: 8];
        end
        frm[d][8] = x;
`ifdef UART_FRAME_CHECKSUM_EN
        flen[d] = 9;
`else
        flen[d] = 8;
`endif
        pos[d]       = 0;
        in_frame[d]  = 1'b1;
        grant_cyc[d] = cyc;
        gid_m[d]     = 3'(w);
        ptr_m[d]     = (w + 1) % nr;
      end
    end else begin
      check_eq({pre, "req_ready_busy"}, 64'(rq), 64'd0);
    end
  endtask

  task automatic drive(input int d);
    int nr;
    nr = nr_of(d);
    for (int i = 0; i < nr; i++) begin
      case (mode)
        0: if (last_rq[d][i]) rv[d][i] = 1'b0;
        1, 3: begin
          rv[d][i] = 1'b1;
          rd[d][48*i +: 48] = {6{8'(8'hAA + 8'h11 * i)}};
        end
        default: begin
          if (last_rq[d][i]) rv[d][i] = 1'b0;
          else if (!rv[d][i]) begin
            if ($urandom_range(0, 5) == 0) begin
              rv[d][i] = 1'b1;
              rd[d][48*i +: 48] = 48'({$urandom(), $urandom()});
            end
          end else if ($urandom_range(0, 40) == 0) rv[d][i] = 1'b0;
          else if ($urandom_range(0, 5) == 0) rd[d][48*i +: 48] = 48'({$urandom(), $urandom()});
        end
      endcase
    end
    case (mode)
      2:       br[d] = (cyc % 3 == 0);
      4:       br[d] = ($urandom_range(0, 3) != 0);
      default: br[d] = 1'b1;
    endcase
  endtask

  initial begin
    rv = '0;
    rd = '0;
    br = '1;
    for (int d = 0; d < 2; d++) begin
      last_rq[d]   = '0;
      grant_cyc[d] = 0;
      flen[d]      = 8;
      model_reset(d);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      cyc = c;
      if (c == 3) begin
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
          rv[d][0]     = 1'b1;
          rd[d][47:0]  = 48'h0102_0304_0506;
        end
      end
      if (c == 60)  mode = 1;
      if (c == 160) mode = 2;
      if (c == 400) mode = 3;
      if (c == 600) mode = 4;
      if (mode == 3 && !did_rst && in_frame[0] && pos[0] == 3) begin
        reset_n = 1'b0;
        did_rst = 1'b1;
      end else if (!reset_n && c > 3) begin
        reset_n = 1'b1;
      end
      drive(0);
      drive(1);
      #1;
      step(0);
      step(1);
      rst_prev = !reset_n;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
